// File: rtl/ltc5548_sys_sample_capture_writer_if.sv
// Sample stream and capture-RAM write port bundled between the capture writer and its neighbours.
// master is the writer side; slave is the feeder/RAM side.
interface ltc5548_sys_sample_capture_writer_if #(
  parameter int ADDR_W   = 15,
  parameter int SAMPLE_W = 16
);
  logic                  s_valid;
  logic [SAMPLE_W-1:0]   s_data;
  logic                  s_ready;
  logic [ADDR_W-1:0]     m_address;
  logic [3:0]            m_byteenable;
  logic                  m_chipselect;
  logic                  m_write;
  logic [2*SAMPLE_W-1:0] m_writedata;
  logic                  m_clken;

  modport master (
    input  s_valid, s_data,
    output s_ready, m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );
endinterface

// File: rtl/ltc5548_sys_sample_capture_writer.sv
// Packs 16-bit samples two per word and writes a triggered burst into the capture RAM.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_ARMED   | parameters latched, waiting for trigger
// S_CAPTURE | accepting samples, one per cycle
// S_FLUSH   | odd count: half-filled last word being written
// S_DONE    | one-cycle completion pulse
module ltc5548_sys_sample_capture_writer #(
  parameter int ADDR_W   = 15,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                trigger,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_samples,
  ltc5548_sys_sample_capture_writer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]     base_q;
  logic [CNT_W-1:0]      rem_q;
  logic                  half_q;
  logic [SAMPLE_W-1:0]   low_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2*SAMPLE_W-1:0] wdata_q;
  logic [3:0]            be_q;
  logic                  wr_q;
  logic                  accept;
  logic                  last;
  logic                  take;

  assign accept = (state_q == S_CAPTURE) && bus.s_valid;
  assign last   = accept && (rem_q == CNT_W'(1));
  // A sample arriving on the abort cycle is dropped rather than written.
  assign take   = accept && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ARMED;
      S_ARMED: begin
        if (abort)        state_d = S_IDLE;
        else if (trigger) state_d = (rem_q == '0) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort)     state_d = S_IDLE;
        else if (last) state_d = half_q ? S_DONE : S_FLUSH;
      end
      S_FLUSH:   state_d = abort ? S_IDLE : S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_ARMED:   busy = 1'b1;
      S_CAPTURE: begin
        busy        = 1'b1;
        bus.s_ready = 1'b1;
      end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  // Write port is fully registered; the strobe lands the cycle after the completing sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q        <= '0;
      rem_q         <= '0;
      half_q        <= 1'b0;
      low_q         <= '0;
      words_written <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= 4'b0000;
      wr_q          <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (state_q == S_IDLE && start) begin
        base_q        <= base_addr;
        rem_q         <= num_samples;
        half_q        <= 1'b0;
        low_q         <= '0;
        words_written <= '0;
      end else if (take) begin
        rem_q <= rem_q - CNT_W'(1);
        if (half_q) begin
          half_q        <= 1'b0;
          addr_q        <= base_q + words_written[ADDR_W-1:0];
          wdata_q       <= {bus.s_data, low_q};
          be_q          <= 4'b1111;
          wr_q          <= 1'b1;
          words_written <= words_written + (ADDR_W+1)'(1);
        end else begin
          half_q <= 1'b1;
          low_q  <= bus.s_data;
          if (last) begin
            addr_q        <= base_q + words_written[ADDR_W-1:0];
            wdata_q       <= {{SAMPLE_W{1'b0}}, bus.s_data};
            be_q          <= 4'b0011;
            wr_q          <= 1'b1;
            words_written <= words_written + (ADDR_W+1)'(1);
          end
        end
      end
    end
  end

  assign bus.m_address    = addr_q;
  assign bus.m_writedata  = wdata_q;
  assign bus.m_byteenable = be_q;
  assign bus.m_write      = wr_q;
  assign bus.m_chipselect = wr_q;
  assign bus.m_clken      = 1'b1;

endmodule

// File: tb/tb_ltc5548_sys_sample_capture_writer.sv
// Directed bench: expected RAM writes are queued by the stimulus and checked by a write monitor.
module tb_ltc5548_sys_sample_capture_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, trigger;
  logic [14:0] base_addr;
  logic [15:0] num_samples;
  logic        busy, done;
  logic [15:0] words_written;

  ltc5548_sys_sample_capture_writer_if #(.ADDR_W(15), .SAMPLE_W(16)) bus ();

  ltc5548_sys_sample_capture_writer #(.ADDR_W(15), .SAMPLE_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .trigger(trigger),
    .base_addr(base_addr), .num_samples(num_samples), .bus(bus),
    .busy(busy), .done(done), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vec = 0;
  int  err = 0;
  int  wr_cnt = 0;

  always @(negedge clk) begin
    if (!reset && bus.m_write) begin
      wr_cnt++;
      vec++;
      if (exp_q.size() == 0) begin
        err++;
        $display("FAIL unexpected_write: got addr=%h data=%h be=%b, required no write",
                 bus.m_address, bus.m_writedata, bus.m_byteenable);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.m_address, bus.m_writedata, bus.m_byteenable, bus.m_chipselect} !==
            {mon_e.a, mon_e.d, mon_e.be, 1'b1}) begin
          err++;
          $display("FAIL ram_write: got addr=%h data=%h be=%b cs=%b, required addr=%h data=%h be=%b cs=1",
                   bus.m_address, bus.m_writedata, bus.m_byteenable, bus.m_chipselect,
                   mon_e.a, mon_e.d, mon_e.be);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    vec++;
    if (got !== req) begin
      err++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic expect_wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.a = a; e.d = d; e.be = be;
    exp_q.push_back(e);
  endtask

  // All tasks start and end at posedge+1.
  task automatic do_start(input logic [14:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic trig();
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    bit ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    chk("sample_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input logic [15:0] exp_ww);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("done_seen", 64'(found), 64'd1);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("words_written", 64'(words_written), 64'(exp_ww));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int wc;
    int dc;
    reset = 1'b1; start = 1'b0; abort = 1'b0; trigger = 1'b0;
    base_addr = '0; num_samples = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;

    repeat (2) @(negedge clk);
    chk("reset_ctrl",
        64'({bus.m_write, bus.m_chipselect, busy, done, bus.s_ready, bus.m_byteenable, bus.m_clken}),
        64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1}));
    chk("reset_data", {1'b0, bus.m_address, bus.m_writedata, words_written}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // even count, back-to-back
    expect_wr(15'h0100, 32'h2222_1111, 4'b1111);
    expect_wr(15'h0101, 32'h4444_3333, 4'b1111);
    do_start(15'h0100, 16'd4);
    chk("busy_armed", 64'(busy), 64'd1);
    trig();
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
    wait_done(16'd2);

    // odd count with flush
    expect_wr(15'h0010, 32'hBBBB_AAAA, 4'b1111);
    expect_wr(15'h0011, 32'h0000_CCCC, 4'b0011);
    do_start(15'h0010, 16'd3);
    trig();
    send(16'hAAAA); send(16'hBBBB); send(16'hCCCC);
    wait_done(16'd2);

    // address wrap
    expect_wr(15'h7FFF, 32'h0002_0001, 4'b1111);
    expect_wr(15'h0000, 32'h0004_0003, 4'b1111);
    do_start(15'h7FFF, 16'd4);
    trig();
    send(16'h0001); send(16'h0002); send(16'h0003); send(16'h0004);
    wait_done(16'd2);

    // samples offered before trigger are not taken
    expect_wr(15'h0300, 32'h6666_5555, 4'b1111);
    do_start(15'h0300, 16'd2);
    wc = wr_cnt;
    bus.s_valid = 1'b1; bus.s_data = 16'h5555;
    repeat (3) begin
      @(negedge clk);
      chk("ready_armed", 64'(bus.s_ready), 64'd0);
      @(posedge clk); #1;
    end
    chk("no_write_armed", 64'(wr_cnt), 64'(wc));
    trig();
    send(16'h5555); send(16'h6666);
    wait_done(16'd1);

    // abort after 3 of 8
    expect_wr(15'h0200, 32'h0202_0101, 4'b1111);
    do_start(15'h0200, 16'd8);
    trig();
    send(16'h0101); send(16'h0202); send(16'h0303);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    dc = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("abort_no_done", 64'(dc), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ww", 64'(words_written), 64'd1);
    chk("abort_no_flush", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    expect_wr(15'h0200, 32'h0B0B_0A0A, 4'b1111);
    do_start(15'h0200, 16'd2);
    trig();
    send(16'h0A0A); send(16'h0B0B);
    wait_done(16'd1);

    // zero-length request
    wc = wr_cnt;
    do_start(15'h0400, 16'd0);
    trig();
    wait_done(16'd0);
    chk("zero_no_write", 64'(wr_cnt), 64'(wc));

    // reset while capturing
    do_start(15'h0500, 16'd8);
    trig();
    send(16'h0001); send(16'h0002);
    chk("write_before_reset", 64'(bus.m_write), 64'd1);
    reset = 1'b1;
    #1;
    chk("reset_mid_write", 64'(bus.m_write), 64'd0);
    chk("reset_mid_busy", 64'({busy, bus.s_ready}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
